uart_rx_bram_loader: RTL and testbench

Controller that sequences UART reception of an image into block RAM. It consumes the oversampling tick from the baud rate generator and samples the serial line at mid-bit, LSB first, to assemble 8N1 bytes. Each good byte is written to consecutive BRAM addresses until the programmed image size is reached. It sits between the baud rate generator (which it times against) and the image BRAM write port.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx_bram_loader.sv | 145 ++++++++++++++
 tb/tb_uart_rx_bram_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive / BRAM image loader.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHunt,
    StStart,
    StData,
    StStop,
    StWrite,
    StDone
  } state_e;

  localparam int unsigned DivisionsDefault = 16;
  localparam int unsigned TickW            = $clog2(DivisionsDefault);
  localparam int unsigned DataW            = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector on the
// synchronized value. Resets to the idle (high) level so reset never fakes an edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_bram_loader.sv
// Receives 8N1 bytes timed by an external oversampling tick and writes each good
// byte to consecutive BRAM addresses until the programmed image size is reached.
module uart_rx_bram_loader
  import uart_pkg::*;
#(
  parameter int unsigned DIVISIONS = DivisionsDefault,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned IMG_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_baud,
  input  logic              rx,
  input  logic              start,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DataW-1:0]  bram_din,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam int unsigned CntW = $clog2(DIVISIONS);
  localparam int unsigned IdxW = $clog2(DataW);

  localparam logic [CntW-1:0]   HalfLast = CntW'(DIVISIONS / 2 - 1);
  localparam logic [CntW-1:0]   FullLast = CntW'(DIVISIONS - 1);
  localparam logic [IdxW-1:0]   IdxLast  = IdxW'(DataW - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(IMG_BYTES - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  state_e          state_q;
  logic [CntW-1:0] tick_q;
  logic [IdxW-1:0] bit_idx_q;
  logic [DataW-1:0] shift_q;
  logic            fall_pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      fall_pend_q <= 1'b0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StHunt;
            bram_addr   <= '0;
            frame_err   <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            fall_pend_q <= 1'b0;
          end
        end
        StHunt: begin
          if (fall || fall_pend_q) begin
            state_q     <= StStart;
            tick_q      <= '0;
            fall_pend_q <= 1'b0;
          end
        end
        StStart: begin
          if (en_baud) begin
            if (tick_q == HalfLast) begin
              tick_q <= '0;
              if (!rx_s) begin
                state_q   <= StData;
                bit_idx_q <= '0;
              end else begin
                state_q <= StHunt;
              end
            end else begin
              tick_q <= tick_q + CntW'(1);
            end
          end
        end
        StData: begin
          if (en_baud) begin
            if (tick_q == FullLast) begin
              tick_q             <= '0;
              shift_q[bit_idx_q] <= rx_s;
              if (bit_idx_q == IdxLast) begin
                state_q <= StStop;
              end else begin
                bit_idx_q <= bit_idx_q + IdxW'(1);
              end
            end else begin
              tick_q <= tick_q + CntW'(1);
            end
          end
        end
        StStop: begin
          if (en_baud) begin
            if (tick_q == FullLast) begin
              tick_q <= '0;
              if (rx_s) begin
                state_q  <= StWrite;
                bram_we  <= 1'b1;
                bram_din <= shift_q;
              end else begin
                frame_err <= 1'b1;
                state_q   <= StHunt;
              end
            end else begin
              tick_q <= tick_q + CntW'(1);
            end
          end
        end
        StWrite: begin
          // Remember an edge seen here so HUNT can still start on it next cycle.
          fall_pend_q <= fall;
          if (bram_addr == LastAddr) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            bram_addr <= bram_addr + ADDR_W'(1);
            state_q   <= StHunt;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_bram_loader.sv
// Self-checking bench: serial frames in, BRAM writes compared against a
// transaction-level model of the image loader.
module tb_uart_rx_bram_loader;

  localparam int unsigned Div    = 16;
  localparam int unsigned AddrW  = 2;
  localparam int unsigned Img    = 4;
  localparam int unsigned BitClk = Div * 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en_baud = 1'b0;
  logic             rx = 1'b1;
  logic             start = 1'b0;
  logic             bram_we;
  logic [AddrW-1:0] bram_addr;
  logic [7:0]       bram_din;
  logic             busy;
  logic             done;
  logic             frame_err;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_bram_loader #(
    .DIVISIONS (Div),
    .ADDR_W    (AddrW),
    .IMG_BYTES (Img)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_baud   (en_baud),
    .rx        (rx),
    .start     (start),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  logic [1:0] bdiv = 2'd0;
  always @(posedge clk) begin
    bdiv    <= bdiv + 2'd1;
    en_baud <= (bdiv == 2'd3);
  end

  // Observed writes
  logic [AddrW-1:0] wr_addr[$];
  logic [7:0]       wr_data[$];
  int               we_multi = 0;
  logic             we_prev = 1'b0;

  always @(negedge clk) begin
    if (bram_we) begin
      wr_addr.push_back(bram_addr);
      wr_data.push_back(bram_din);
      if (we_prev) we_multi++;
    end
    we_prev = bram_we;
  end

  // Reference model
  bit               m_active;
  bit               m_done;
  bit               m_ferr;
  int               m_addr;
  logic [AddrW-1:0] exp_addr[$];
  logic [7:0]       exp_data[$];

  task automatic model_clear();
    m_active = 0; m_done = 0; m_ferr = 0; m_addr = 0;
    exp_addr.delete(); exp_data.delete();
    wr_addr.delete(); wr_data.delete();
    we_multi = 0;
  endtask

  task automatic model_start();
    if (!m_active) begin
      m_active = 1; m_done = 0; m_ferr = 0; m_addr = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (m_active) begin
      if (!stop_ok) begin
        m_ferr = 1;
      end else begin
        exp_addr.push_back(AddrW'(m_addr));
        exp_data.push_back(b);
        if (m_addr == Img - 1) begin
          m_active = 0;
          m_done   = 1;
        end else begin
          m_addr++;
        end
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int idle);
    rx = 1'b0;
    repeat (BitClk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BitClk) @(negedge clk);
    end
    rx = stop_ok;
    repeat (BitClk) @(negedge clk);
    rx = 1'b1;
    repeat (idle) @(negedge clk);
    model_byte(b, stop_ok);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    model_start();
  endtask

  task automatic apply_reset();
    rx = 1'b1;
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk) rst = 1'b1;
    #1;
    n_cmp++;
    if ({bram_we, bram_addr, bram_din, busy, done, frame_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got we=%b addr=%0d din=%h busy=%b done=%b ferr=%b, want all 0",
               bram_we, bram_addr, bram_din, busy, done, frame_err);
    end
    apply_reset();
  endtask

  task automatic test_basic_load();
    logic [7:0] bytes[4] = '{8'h55, 8'hA3, 8'h00, 8'hFF};
    apply_reset();
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL basic_busy_rise: got %b want 1", busy);
    end
    foreach (bytes[i]) send_frame(bytes[i], 1'b1, 20);
    n_cmp++;
    if (wr_addr.size() != exp_addr.size()) begin
      n_err++; $display("FAIL basic_count: got %0d writes want %0d", wr_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      n_cmp++;
      if ({wr_addr[i], wr_data[i]} !== {exp_addr[i], exp_data[i]}) begin
        n_err++;
        $display("FAIL basic_write%0d: got addr=%0d data=%h want addr=%0d data=%h",
                 i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
    end
    n_cmp++;
    if ({done, busy, frame_err, bram_addr} !== {1'b1, 1'b0, 1'b0, AddrW'(Img - 1)}) begin
      n_err++;
      $display("FAIL basic_final: got done=%b busy=%b ferr=%b addr=%0d want 1 0 0 %0d",
               done, busy, frame_err, bram_addr, Img - 1);
    end
    n_cmp++;
    if (we_multi != 0) begin
      n_err++; $display("FAIL basic_we_width: got %0d multi-cycle pulses want 0", we_multi);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    pulse_start();
    rx = 1'b0;
    repeat (3 * 4) @(negedge clk);
    rx = 1'b1;
    repeat (120) @(negedge clk);
    n_cmp++;
    if (wr_addr.size() != 0 || frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_reject: got %0d writes ferr=%b want 0 writes ferr=0",
               wr_addr.size(), frame_err);
    end
    send_frame(8'h3C, 1'b1, 20);
    n_cmp++;
    if (wr_addr.size() != 1 || {wr_addr[0], wr_data[0]} !== {exp_addr[0], exp_data[0]}) begin
      n_err++;
      $display("FAIL glitch_next_byte: got %0d writes first=%0d/%h want 1 write 0/3c",
               wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : '0,
               (wr_data.size() > 0) ? wr_data[0] : '0);
    end
  endtask

  task automatic test_framing();
    apply_reset();
    pulse_start();
    send_frame(8'h81, 1'b0, 40);
    n_cmp++;
    if (frame_err !== 1'b1 || wr_addr.size() != 0) begin
      n_err++;
      $display("FAIL frame_bad_stop: got ferr=%b writes=%0d want ferr=1 writes=0",
               frame_err, wr_addr.size());
    end
    send_frame(8'h7E, 1'b1, 20);
    n_cmp++;
    if (wr_addr.size() != 1 || {wr_addr[0], wr_data[0]} !== {exp_addr[0], exp_data[0]}
        || frame_err !== m_ferr) begin
      n_err++;
      $display("FAIL frame_recovery: got writes=%0d ferr=%b want 1 write of 7e at 0, ferr=1",
               wr_addr.size(), frame_err);
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b = 8'hA5;
    apply_reset();
    pulse_start();
    rx = 1'b0;
    repeat (BitClk) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BitClk) @(negedge clk);
    end
    rx = b[4];
    repeat (BitClk / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bram_we, bram_addr, bram_din, busy, done, frame_err} !== '0) begin
      n_err++;
      $display("FAIL midbyte_reset: got we=%b addr=%0d din=%h busy=%b done=%b ferr=%b, want all 0",
               bram_we, bram_addr, bram_din, busy, done, frame_err);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    model_clear();
    repeat (20) @(negedge clk);
    send_frame(8'h12, 1'b1, 20);
    send_frame(8'h34, 1'b1, 20);
    n_cmp++;
    if (wr_addr.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL midbyte_idle: got writes=%0d busy=%b done=%b want 0 0 0",
               wr_addr.size(), busy, done);
    end
  endtask

  task automatic test_restart();
    apply_reset();
    pulse_start();
    send_frame(8'h11, 1'b1, 20);
    send_frame(8'hEE, 1'b0, 30);
    send_frame(8'h22, 1'b1, 20);
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1 || bram_addr !== AddrW'(2)) begin
      n_err++;
      $display("FAIL restart_ignored: got busy=%b addr=%0d want busy=1 addr=2", busy, bram_addr);
    end
    send_frame(8'h33, 1'b1, 20);
    send_frame(8'h44, 1'b1, 20);
    n_cmp++;
    if (wr_addr.size() != 4 || wr_addr[3] !== AddrW'(3) || wr_data[3] !== 8'h44) begin
      n_err++;
      $display("FAIL wrap_last_write: got writes=%0d want 4 ending 3/44", wr_addr.size());
    end
    repeat (50) @(negedge clk);
    n_cmp++;
    if ({done, busy, frame_err, bram_addr} !== {m_done, m_active, m_ferr, AddrW'(3)}) begin
      n_err++;
      $display("FAIL wrap_done_hold: got done=%b busy=%b ferr=%b addr=%0d want 1 0 1 3",
               done, busy, frame_err, bram_addr);
    end
    wr_addr.delete(); wr_data.delete(); exp_addr.delete(); exp_data.delete();
    pulse_start();
    n_cmp++;
    if ({done, frame_err, busy} !== {m_done, m_ferr, m_active}) begin
      n_err++;
      $display("FAIL restart_done: got done=%b ferr=%b busy=%b want 0 0 1", done, frame_err, busy);
    end
    send_frame(8'h99, 1'b1, 20);
    n_cmp++;
    if (wr_addr.size() != 1 || {wr_addr[0], wr_data[0]} !== {exp_addr[0], exp_data[0]}) begin
      n_err++;
      $display("FAIL restart_addr0: got writes=%0d want one write of 99 at 0", wr_addr.size());
    end
  endtask

  task automatic test_random_back_to_back();
    apply_reset();
    pulse_start();
    for (int i = 0; i < 20 && !m_done; i++) begin
      logic [7:0] b;
      bit         ok;
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok, ok ? $urandom_range(0, 3) * 8 : 16 + $urandom_range(0, 16));
    end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (wr_addr.size() != exp_addr.size()) begin
      n_err++; $display("FAIL random_count: got %0d writes want %0d", wr_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      n_cmp++;
      if ({wr_addr[i], wr_data[i]} !== {exp_addr[i], exp_data[i]}) begin
        n_err++;
        $display("FAIL random_write%0d: got addr=%0d data=%h want addr=%0d data=%h",
                 i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
    end
    n_cmp++;
    if ({done, busy, frame_err} !== {m_done, m_active, m_ferr} || we_multi != 0) begin
      n_err++;
      $display("FAIL random_status: got done=%b busy=%b ferr=%b multi=%0d want %b %b %b 0",
               done, busy, frame_err, we_multi, m_done, m_active, m_ferr);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_glitch();
    test_framing();
    test_reset_mid_byte();
    test_restart();
    test_random_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
